cla_add_scheduler: RTL and testbench

Multi-word add sequencer and two-port arbiter built around a single `carry_lookahead_adder_16_bit` instance. It accepts wide add requests (16·NUM_WORDS bits plus carry-in) from two requesters and grants them round-robin. Each granted operation is executed one 16-bit word per cycle through the shared adder, chaining the carry between words. The full-width sum, including carry-out, is returned on a single result port with valid/ready flow control and a requester tag.

---
 rtl/cla_add_scheduler.sv | 272 +++++++++++++++++++++++++++
 tb/tb_cla_add_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_add_scheduler.sv
// -----------------------------------------------------------------------------
// cla_add_scheduler
//
// Two-requester multi-word add sequencer built around one shared 16-bit
// carry-lookahead adder. Each accepted operation is added one 16-bit word per
// cycle, least-significant word first. The carry is chained between words, and
// the final carry-out is kept as bit W of the result.
//
// Parameters
//   NUM_WORDS     number of 16-bit words per operand (1..8), W = 16*NUM_WORDS
//
// Ports
//   clk_i         clock, rising edge
//   rst_n_i       synchronous active-low reset
//   reqK_valid_i  requester K has an operation pending (K = 0, 1)
//   reqK_ready_o  requester K operation accepted this cycle
//   reqK_a_i/b_i  requester K operands (W bits)
//   reqK_carry_i  requester K carry-in
//   res_valid_o   result available
//   res_ready_i   consumer takes the result
//   res_sum_o     A + B + carry, bit W is the carry-out
//   res_id_o      requester that owns the result
//   busy_o        high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module cla_add_scheduler #(
    parameter int NUM_WORDS = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    req0_valid_i,
    output logic                    req0_ready_o,
    input  logic [16*NUM_WORDS-1:0] req0_a_i,
    input  logic [16*NUM_WORDS-1:0] req0_b_i,
    input  logic                    req0_carry_i,
    input  logic                    req1_valid_i,
    output logic                    req1_ready_o,
    input  logic [16*NUM_WORDS-1:0] req1_a_i,
    input  logic [16*NUM_WORDS-1:0] req1_b_i,
    input  logic                    req1_carry_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [16*NUM_WORDS:0]   res_sum_o,
    output logic                    res_id_o,
    output logic                    busy_o
);

    localparam int W     = 16 * NUM_WORDS;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cy_q, cy_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             cin_q, cin_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             grant_s;
    logic             grant_valid_s;
    logic             accept_s;
    logic [15:0]      add_a_s;
    logic [15:0]      add_b_s;
    logic             add_cin_s;
    logic [15:0]      add_sum_s;
    logic             add_cout_s;

    // Round-robin grant: a lone requester wins; on contention the one that
    // was not served last wins.
    always_comb begin
        grant_s       = 1'b0;
        grant_valid_s = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_s       = ~last_q;
            grant_valid_s = 1'b1;
        end else if (req0_valid_i) begin
            grant_s       = 1'b0;
            grant_valid_s = 1'b1;
        end else if (req1_valid_i) begin
            grant_s       = 1'b1;
            grant_valid_s = 1'b1;
        end else begin
            grant_s       = 1'b0;
            grant_valid_s = 1'b0;
        end
    end

    assign accept_s     = (state_q == S_IDLE) && grant_valid_s;
    assign req0_ready_o = accept_s && !grant_s;
    assign req1_ready_o = accept_s && grant_s;

    // Shared-adder operand selection: current word of each captured operand;
    // word 0 takes the captured carry, later words take the chained carry.
    always_comb begin
        add_a_s   = 16'(a_q >> {idx_q, 4'b0000});
        add_b_s   = 16'(b_q >> {idx_q, 4'b0000});
        add_cin_s = (idx_q == IDX_ZERO) ? cin_q : cy_q;
    end

    carry_lookahead_adder_16_bit u_adder (
        .a_i   (add_a_s),
        .b_i   (add_b_s),
        .c_i   (add_cin_s),
        .sum_o (add_sum_s),
        .c_o   (add_cout_s)
    );

    // Sequencer next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    a_d     = grant_s ? req1_a_i : req0_a_i;
                    b_d     = grant_s ? req1_b_i : req0_b_i;
                    cin_d   = grant_s ? req1_carry_i : req0_carry_i;
                    id_d    = grant_s;
                    last_d  = grant_s;
                    idx_d   = IDX_ZERO;
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                for (int k = 0; k < NUM_WORDS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*16 +: 16] = add_sum_s;
                    end else begin
                        sum_d[k*16 +: 16] = sum_q[k*16 +: 16];
                    end
                end
                cy_d = add_cout_s;
                if (idx_q == IDX_LAST) begin
                    cout_d  = add_cout_s;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                // No accept here: the handshake edge only returns to idle.
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= IDX_ZERO;
            cy_q    <= 1'b0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            cin_q   <= 1'b0;
            sum_q   <= {W{1'b0}};
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign res_valid_o = (state_q == S_DONE);
    assign res_sum_o   = {cout_q, sum_q};
    assign res_id_o    = id_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// -----------------------------------------------------------------------------
// carry_lookahead_adder_16_bit
//
// Two-level 16-bit carry-lookahead adder: four 4-bit lookahead groups whose
// group generate/propagate feed a second lookahead stage for the group carries.
//
// Ports
//   a_i, b_i   16-bit addends
//   c_i        carry-in
//   sum_o      16-bit sum
//   c_o        carry-out
// -----------------------------------------------------------------------------
module carry_lookahead_adder_16_bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] sum_o,
    output logic        c_o
);

    // 4-bit lookahead: carries into bits 0..3 plus the carry out of bit 3.
    // With ci = 0 the top carry is the group generate.
    function automatic logic [4:0] lookahead4(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       ci);
        logic [4:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [3:0]  grp_g_s;
    logic [3:0]  grp_p_s;
    logic [4:0]  grp_c_s;
    logic [15:0] c_s;

    // Bit and group generate/propagate, then group carries, then bit carries.
    always_comb begin
        logic [4:0] tmp;
        g_s = a_i & b_i;
        p_s = a_i ^ b_i;
        for (int k = 0; k < 4; k++) begin
            tmp        = lookahead4(g_s[k*4 +: 4], p_s[k*4 +: 4], 1'b0);
            grp_g_s[k] = tmp[4];
            grp_p_s[k] = &p_s[k*4 +: 4];
        end
        grp_c_s = lookahead4(grp_g_s, grp_p_s, c_i);
        for (int k = 0; k < 4; k++) begin
            tmp            = lookahead4(g_s[k*4 +: 4], p_s[k*4 +: 4], grp_c_s[k]);
            c_s[k*4 +: 4]  = tmp[3:0];
        end
        sum_o = p_s ^ c_s;
        c_o   = grp_c_s[4];
    end

endmodule

// File: tb/tb_cla_add_scheduler.sv
`timescale 1ns/1ps
module tb_cla_add_scheduler;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_carry, req1_carry;
    logic        res_valid, res_ready, res_id, busy;
    logic [32:0] res_sum;

    // single-word build
    logic        s_valid, s_ready, s1_valid, s1_ready;
    logic [15:0] s_a, s_b, s1_a, s1_b;
    logic        s_carry, s1_carry;
    logic        s_res_valid, s_res_ready, s_res_id, s_busy;
    logic [16:0] s_res_sum;

    int tests;
    int failed;

    cla_add_scheduler #(.NUM_WORDS(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_carry_i(req0_carry),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_carry_i(req1_carry),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_sum_o(res_sum), .res_id_o(res_id), .busy_o(busy)
    );

    cla_add_scheduler #(.NUM_WORDS(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(s_valid), .req0_ready_o(s_ready),
        .req0_a_i(s_a), .req0_b_i(s_b), .req0_carry_i(s_carry),
        .req1_valid_i(s1_valid), .req1_ready_o(s1_ready),
        .req1_a_i(s1_a), .req1_b_i(s1_b), .req1_carry_i(s1_carry),
        .res_valid_o(s_res_valid), .res_ready_i(s_res_ready),
        .res_sum_o(s_res_sum), .res_id_o(s_res_id), .busy_o(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // From just before the accept edge: count ADD edges, check result, handshake.
    task automatic finish_op(input string tag, input logic [32:0] exp_sum, input logic exp_id);
        int n;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!res_valid && n < 12);
        chk({tag, "_latency"}, 64'(n), 64'd2);
        chk({tag, "_sum"}, 64'(res_sum), 64'(exp_sum));
        chk({tag, "_id"}, 64'(res_id), 64'(exp_id));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_clr"}, 64'(res_valid), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic id, input logic [31:0] a,
                          input logic [31:0] b, input logic c, input logic [32:0] exp_sum);
        int w;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_carry = c;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_carry = c;
        end
        w = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && w < 12) begin
            @(negedge clk); w++;
        end
        chk({tag, "_ready"}, 64'(id ? req1_ready : req0_ready), 64'd1);
        finish_op(tag, exp_sum, id);
    endtask

    initial begin
        int grants, results, last_cyc, w;
        tests = 0; failed = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req0_carry = 1'b0;
        req1_a = 32'd0; req1_b = 32'd0; req1_carry = 1'b0;
        res_ready = 1'b0;
        s_valid = 1'b0; s1_valid = 1'b0; s_a = 16'd0; s_b = 16'd0;
        s1_a = 16'd0; s1_b = 16'd0; s_carry = 1'b0; s1_carry = 1'b0;
        s_res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_sum", 64'(res_sum), 64'd0);
        chk("rst_id", 64'(res_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        chk("rst_ready1", 64'(req1_ready), 64'd0);

        run_op("op_f0f0", 1'b0, 32'h0000F0F0, 32'h00000F0F, 1'b0, 33'h0FFFF);
        run_op("op_ripple", 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h100000000);
        run_op("op_allones", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1FFFFFFFF);

        // Round-robin with both requesters always valid
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2;  req0_carry = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_carry = 1'b0;
        res_ready = 1'b1;
        grants = 0; results = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40 && results < 4; cyc++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("rr_grant", 64'(req1_ready), 64'(grants % 2));
                if (grants > 0) chk("rr_interval", 64'(cyc - last_cyc), 64'd4);
                last_cyc = cyc;
                grants++;
            end
            if (res_valid) begin
                chk("rr_id", 64'(res_id), 64'(results % 2));
                chk("rr_sum", 64'(res_sum), (results % 2 == 1) ? 64'd30 : 64'd3);
                results++;
            end
        end
        chk("rr_results", 64'(results), 64'd4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Backpressure: hold DONE for three cycles with req1 waiting
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6; req0_carry = 1'b1;
        @(negedge clk);
        chk("bp_ready0", 64'(req0_ready), 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd8; req1_carry = 1'b0;
        w = 0;
        @(negedge clk);
        while (!res_valid && w < 12) begin
            @(negedge clk); w++;
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_sum", 64'(res_sum), 64'd12);
            chk("bp_id", 64'(res_id), 64'd0);
            chk("bp_ready0_low", 64'(req0_ready), 64'd0);
            chk("bp_ready1_low", 64'(req1_ready), 64'd0);
            @(negedge clk);
        end
        chk("bp_hold_valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("bp_released", 64'(res_valid), 64'd0);
        chk("bp_waiter_ready", 64'(req1_ready), 64'd1);
        finish_op("bp_waiter", 33'd15, 1'b1);

        // Reset in the middle of an ADD (req0 op so `last` must be restored)
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_carry = 1'b0;
        @(negedge clk);
        chk("rstadd_ready0", 64'(req0_ready), 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstadd_busy", 64'(busy), 64'd0);
        chk("rstadd_valid", 64'(res_valid), 64'd0);
        chk("rstadd_sum", 64'(res_sum), 64'd0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd200; req0_carry = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd1;   req1_b = 32'd1;   req1_carry = 1'b0;
        @(negedge clk);
        chk("rstadd_win0", 64'(req0_ready), 64'd1);
        chk("rstadd_lose1", 64'(req1_ready), 64'd0);
        finish_op("rstadd_op", 33'd300, 1'b0);

        // Single-word build
        @(posedge clk); #1;
        s_valid = 1'b1; s_a = 16'hFFFF; s_b = 16'h1111; s_carry = 1'b1;
        @(negedge clk);
        chk("nw1_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("nw1_busy", 64'(s_busy), 64'd1);
        chk("nw1_early", 64'(s_res_valid), 64'd0);
        @(negedge clk);
        chk("nw1_valid", 64'(s_res_valid), 64'd1);
        chk("nw1_sum", 64'(s_res_sum), 64'h11111);
        chk("nw1_id", 64'(s_res_id), 64'd0);
        s_res_ready = 1'b1;
        @(posedge clk); #1;
        s_res_ready = 1'b0;
        @(negedge clk);
        chk("nw1_idle", 64'(s_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
